// File: rtl/bist_pkg.sv
// Shared BIST constants: FSM state encoding, LFSR geometry/taps and default seed/golden values.
package bist_pkg;

   localparam int unsigned LFSR_W = 12;
   // x^12 + x^6 + x^4 + x + 1 -> feedback from bits 11, 5, 3, 0
   localparam logic [LFSR_W-1:0] TAP_MASK   = 12'h829;
   localparam logic [LFSR_W-1:0] DEF_SEED   = 12'h001;
   localparam logic [LFSR_W-1:0] DEF_GOLDEN = 12'h000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEED,
      ST_RUN,
      ST_DRAIN,
      ST_CHECK,
      ST_DONE
   } state_t;

   // An all-zero seed would lock the LFSR; substitute the minimal non-zero state.
   function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
      return (s == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : s;
   endfunction

endpackage

// File: rtl/bist_pattern_gen_if.sv
// Controller-side bus of the BIST pattern generator (start/result handshake, CUT and MISR hookup).
// BIST_SIG_CAPTURE_EN adds the captured-signature signal.
interface bist_pattern_gen_if
   import bist_pkg::*;
#(
   parameter int unsigned PAT_W = 3
);

   logic              bist_start;
   logic [PAT_W-1:0]  pat_out;
   logic              misr_seed;
   logic              bist_end;
   logic [LFSR_W-1:0] sig_in;
   logic              busy;
   logic              done;
   logic              pass;
   logic              fail;
`ifdef BIST_SIG_CAPTURE_EN
   logic [LFSR_W-1:0] sig_cap;
`endif

   modport master (
      output bist_start, sig_in,
      input  pat_out, misr_seed, bist_end, busy, done, pass, fail
`ifdef BIST_SIG_CAPTURE_EN
      , input sig_cap
`endif
   );

   modport slave (
      input  bist_start, sig_in,
      output pat_out, misr_seed, bist_end, busy, done, pass, fail
`ifdef BIST_SIG_CAPTURE_EN
      , output sig_cap
`endif
   );

endinterface

// File: rtl/bist_lfsr.sv
// 12-bit Fibonacci LFSR with synchronous seed load and step enable; exposes the low OUT_W bits.
module bist_lfsr
   import bist_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED  = DEF_SEED,
   parameter int unsigned       OUT_W = 3
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             load,
   input  logic             enable,
   output logic [OUT_W-1:0] q
);

   logic [LFSR_W-1:0] state_q;

   always_ff @(posedge CLK) begin
      if (!RST || load)
         state_q <= seed_fix(SEED);
      else if (enable)
         state_q <= {state_q[LFSR_W-2:0], ^(state_q & TAP_MASK)};
   end

   assign q = state_q[OUT_W-1:0];

endmodule

// File: rtl/bist_pattern_gen.sv
// BIST controller: sequences MISR seed/freeze around an LFSR pattern run and checks the signature.
// BIST_SIG_CAPTURE_EN keeps a copy of the signature sampled in CHECK.
module bist_pattern_gen
   import bist_pkg::*;
#(
   parameter int unsigned       PAT_W      = 3,
   parameter logic [LFSR_W-1:0] SEED       = DEF_SEED,
   parameter int unsigned       N_PATTERNS = 4095,
   parameter int unsigned       SIG_LAT    = 2,
   parameter logic [LFSR_W-1:0] GOLDEN     = DEF_GOLDEN
) (
   input  logic             CLK,
   input  logic             RST,
   bist_pattern_gen_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(N_PATTERNS + 1);
   localparam int unsigned LAT_W = (SIG_LAT > 1) ? $clog2(SIG_LAT) : 1;

   state_t           state, nxt;
   logic [CNT_W-1:0] cnt;
   logic [LAT_W-1:0] lat_cnt;
   logic [PAT_W-1:0] lfsr_pat;
   logic             busy_d, bist_end_d, misr_seed_d, done_d;
   logic             busy_q, bist_end_q, misr_seed_q, done_q, pass_q, fail_q;

   bist_lfsr #(.SEED(SEED), .OUT_W(PAT_W)) u_lfsr (
      .CLK    (CLK),
      .RST    (RST),
      .load   (state == ST_SEED),
      .enable (state == ST_RUN),
      .q      (lfsr_pat)
   );

   always_ff @(posedge CLK) begin
      if (!RST) state <= ST_IDLE;
      else      state <= nxt;
   end

   // Outputs are decoded from the next state so they register in step with it.
   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE:  if (bus.bist_start) nxt = ST_SEED;
         ST_SEED:  nxt = ST_RUN;
         ST_RUN:   if (cnt == CNT_W'(N_PATTERNS - 1)) nxt = ST_DRAIN;
         ST_DRAIN: if (lat_cnt == LAT_W'(SIG_LAT - 1)) nxt = ST_CHECK;
         ST_CHECK: nxt = ST_DONE;
         ST_DONE:  if (bus.bist_start) nxt = ST_SEED;
         default:  nxt = ST_IDLE;
      endcase
      busy_d      = (nxt == ST_SEED) || (nxt == ST_RUN) || (nxt == ST_DRAIN) || (nxt == ST_CHECK);
      bist_end_d  = (nxt != ST_RUN);
      misr_seed_d = (nxt == ST_SEED);
      done_d      = (nxt == ST_DONE);
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         cnt         <= '0;
         lat_cnt     <= '0;
         busy_q      <= 1'b0;
         bist_end_q  <= 1'b1;
         misr_seed_q <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         cnt         <= (state == ST_RUN)   ? cnt + 1'b1     : '0;
         lat_cnt     <= (state == ST_DRAIN) ? lat_cnt + 1'b1 : '0;
         busy_q      <= busy_d;
         bist_end_q  <= bist_end_d;
         misr_seed_q <= misr_seed_d;
         done_q      <= done_d;
         if (state == ST_CHECK) begin
            pass_q <= (bus.sig_in == GOLDEN);
            fail_q <= (bus.sig_in != GOLDEN);
         end else if (nxt == ST_SEED) begin
            pass_q <= 1'b0;
            fail_q <= 1'b0;
         end
      end
   end

`ifdef BIST_SIG_CAPTURE_EN
   logic [LFSR_W-1:0] sig_cap_q;

   always_ff @(posedge CLK) begin
      if (!RST)                   sig_cap_q <= '0;
      else if (state == ST_CHECK) sig_cap_q <= bus.sig_in;
   end

   assign bus.sig_cap = sig_cap_q;
`endif

   // LFSR is held between runs, so gate the pattern with the registered run flag.
   assign bus.pat_out   = bist_end_q ? '0 : lfsr_pat;
   assign bus.misr_seed = misr_seed_q;
   assign bus.bist_end  = bist_end_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.fail      = fail_q;

endmodule
